// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory port between instruction fetch and the load/store unit,
// with round-robin arbitration, window range checks and read-modify-write for sub-word stores.
module mem_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int unsigned MEM_DEPTH = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out,
    output logic [2:0]  dbg_state
);

    // Handshake: a requester raises req with its fields stable and holds them until the
    // single-cycle ack; any req still high when the arbiter is back in IDLE is a new request.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [32:0] LAST_OFF = 33'(MEM_DEPTH - 4);

    state_t      state;
    state_t      state_next;
    logic        gnt_data;
    logic        last_data;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wr_data_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        grant_data;
    logic        grant_any;
    logic [31:0] sel_addr;
    logic [32:0] offset;
    logic        fault;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        grant_data = d_req && (!if_req || !last_data);
        grant_any  = if_req || d_req;
        sel_addr   = grant_data ? d_addr : if_addr;
        offset     = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
        fault      = (sel_addr < BASE_ADDR) || (offset > LAST_OFF)
                   || (!grant_data && (sel_addr[1:0] != 2'b00))
                   || (grant_data && (d_size == 2'b11));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    if (fault) begin
                        state_next = RESP;
                    end else if (!grant_data || !d_we) begin
                        state_next = READ;
                    end else if (d_size == 2'b10) begin
                        state_next = WRITE;
                    end else begin
                        state_next = MERGE;
                    end
                end
            end
            READ:    state_next = RESP;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_data  <= 1'b0;
            last_data <= 1'b1;
            addr_q    <= 32'h0;
            size_q    <= 2'b00;
            wr_data_q <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt_data  <= grant_data;
                        last_data <= grant_data;
                        addr_q    <= sel_addr;
                        size_q    <= grant_data ? d_size : 2'b10;
                        wr_data_q <= grant_data ? d_wdata : 32'h0;
                        rdata_q   <= 32'h0;
                        err_q     <= fault;
                    end
                end
                READ: rdata_q <= mem_data_out;
                // Keep the untouched upper bytes of the word currently in memory.
                MERGE: begin
                    if (size_q == 2'b00) begin
                        wr_data_q <= {mem_data_out[31:8], wr_data_q[7:0]};
                    end else begin
                        wr_data_q <= {mem_data_out[31:16], wr_data_q[15:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_read_write = (state == WRITE);
        mem_address    = ((state == READ) || (state == MERGE) || (state == WRITE)) ? addr_q : BASE_ADDR;
        mem_data_in    = wr_data_q;
        if_ack         = (state == RESP) && !gnt_data;
        d_ack          = (state == RESP) && gnt_data;
        if_err         = (state == RESP) && !gnt_data && err_q;
        d_err          = (state == RESP) && gnt_data && err_q;
        if_rdata       = ((state == RESP) && !gnt_data) ? rdata_q : 32'h0;
        d_rdata        = ((state == RESP) && gnt_data) ? rdata_q : 32'h0;
        dbg_state      = state;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a byte-array memory model behind the port and a
// transaction-level reference model predicting grant order, latency, data and faults.
module tb_mem_port_arbiter;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 4096;
    localparam int          AW    = 12;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic [2:0]  dbg_state;

    always #5 clock = ~clock;

    mem_port_arbiter #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
        .mem_data_out(mem_data_out), .dbg_state(dbg_state)
    );

    // Physical memory: combinational little-endian read, 4-byte write on posedge.
    logic [7:0]    mem_b    [DEPTH];
    logic [7:0]    init_img [DEPTH];
    logic [7:0]    ref_mem  [DEPTH];
    logic          fill;
    logic          pre_we;
    logic [AW-1:0] pre_idx;
    logic [31:0]   pre_word;
    logic [31:0]   rd_off;
    logic          rd_ok;

    always_comb begin
        rd_off       = mem_address - BASE;
        rd_ok        = (mem_address >= BASE) && (rd_off <= 32'(DEPTH - 4));
        mem_data_out = 32'h0;
        if (rd_ok) begin
            mem_data_out = {mem_b[rd_off[AW-1:0] + AW'(3)], mem_b[rd_off[AW-1:0] + AW'(2)],
                            mem_b[rd_off[AW-1:0] + AW'(1)], mem_b[rd_off[AW-1:0]]};
        end
    end

    always @(posedge clock) begin
        if (fill) begin
            mem_b <= init_img;
        end else if (pre_we) begin
            mem_b[pre_idx]          <= pre_word[7:0];
            mem_b[pre_idx + AW'(1)] <= pre_word[15:8];
            mem_b[pre_idx + AW'(2)] <= pre_word[23:16];
            mem_b[pre_idx + AW'(3)] <= pre_word[31:24];
        end else if (mem_read_write && rd_ok) begin
            mem_b[rd_off[AW-1:0]]          <= mem_data_in[7:0];
            mem_b[rd_off[AW-1:0] + AW'(1)] <= mem_data_in[15:8];
            mem_b[rd_off[AW-1:0] + AW'(2)] <= mem_data_in[23:16];
            mem_b[rd_off[AW-1:0] + AW'(3)] <= mem_data_in[31:24];
        end
    end

    typedef struct {
        bit          side;
        int          cyc;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input longint o);
        return ref_mem[o[AW-1:0]];
    endfunction

    task automatic ref_wr(input longint o, input logic [7:0] b);
        ref_mem[o[AW-1:0]] = b;
    endtask

    function automatic logic [31:0] phys_word(input int off);
        logic [AW-1:0] ix;
        ix = off[AW-1:0];
        return {mem_b[ix + AW'(3)], mem_b[ix + AW'(2)], mem_b[ix + AW'(1)], mem_b[ix]};
    endfunction

    task automatic preload(input int off, input logic [31:0] w);
        pre_idx  = off[AW-1:0];
        pre_word = w;
        pre_we   = 1'b1;
        @(posedge clock);
        #1;
        pre_we = 1'b0;
        for (int k = 0; k < 4; k++) ref_wr(longint'(off + k), w[8*k +: 8]);
    endtask

    // One transaction as seen by the memory map: side 0 = fetch, 1 = data.
    task automatic model_txn(input bit side, input logic [31:0] addr, input bit we,
                             input logic [1:0] sz, input logic [31:0] wd,
                             output bit err, output logic [31:0] rd, output int lat,
                             inout int writes);
        longint a;
        longint o;
        int     nb;
        a   = {32'h0, addr};
        err = (a < longint'(BASE)) || (a > longint'(BASE) + DEPTH - 4)
            || (!side && (addr[1:0] != 2'b00)) || (side && (sz == 2'b11));
        rd  = 32'h0;
        lat = 1;
        if (!err) begin
            o = a - longint'(BASE);
            if (!side || !we) begin
                for (int k = 0; k < 4; k++) rd[8*k +: 8] = ref_rd(o + k);
                lat = 2;
            end else begin
                nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
                for (int k = 0; k < nb; k++) ref_wr(o + k, wd[8*k +: 8]);
                lat = (nb == 4) ? 2 : 3;
                writes++;
            end
        end
    endtask

    task automatic got_ack(input bit side, input int cyc, input bit err, input logic [31:0] rd);
        exp_t  e;
        string nm;
        nm = side ? "d" : "if";
        if (exp_q.size() == 0) begin
            check({nm, "_unexpected_ack"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({nm, "_ack_side"}, 32'(side), 32'(e.side));
        check({nm, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
        check({nm, "_err"}, 32'(err), 32'(e.err));
        check({nm, "_rdata"}, rd, e.rdata);
    endtask

    // Raises the enabled requests together in IDLE and follows them to completion.
    task automatic run_pair(input bit f_en, input logic [31:0] f_addr, input bit dv_en,
                            input bit we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        exp_t        e;
        bit          first_side;
        bit          side;
        bit          err;
        logic [31:0] rd;
        int          lat;
        int          t;
        int          exp_writes;
        int          wr_seen;
        bit          done_f;
        bit          done_d;
        exp_writes = 0;
        wr_seen    = 0;
        t          = -1;
        first_side = (f_en && dv_en) ? !model_last_data : dv_en;
        for (int k = 0; k < 2; k++) begin
            if (k == 1 && !(f_en && dv_en)) break;
            side = (k == 0) ? first_side : !first_side;
            model_last_data = side;
            model_txn(side, side ? a : f_addr, we, sz, wd, err, rd, lat, exp_writes);
            t       = t + 1 + lat;
            e.side  = side;
            e.cyc   = t;
            e.err   = err;
            e.rdata = rd;
            exp_q.push_back(e);
        end
        if_req  = f_en;
        if_addr = f_addr;
        d_req   = dv_en;
        d_we    = we;
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
        done_f  = !f_en;
        done_d  = !dv_en;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clock);
            if (mem_read_write) wr_seen++;
            if (if_ack) begin
                got_ack(1'b0, cyc, if_err, if_rdata);
                done_f = 1'b1;
            end
            if (d_ack) begin
                got_ack(1'b1, cyc, d_err, d_rdata);
                done_d = 1'b1;
            end
            @(posedge clock);
            #1;
            if (done_f) if_req = 1'b0;
            if (done_d) d_req = 1'b0;
            if (done_f && done_d) break;
        end
        check("acks_outstanding", 32'(exp_q.size()), 32'd0);
        check("write_cycles", 32'(wr_seen), 32'(exp_writes));
        exp_q.delete();
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input bit data);
        int          m;
        logic [31:0] a;
        m = $urandom_range(0, 19);
        if (m < 14)      a = BASE + $urandom_range(0, 60);
        else if (m < 16) a = BASE + 32'(DEPTH) - $urandom_range(1, 8);
        else if (m < 18) a = BASE - $urandom_range(1, 8);
        else             a = $urandom;
        if (!data && ($urandom_range(0, 4) != 0)) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mism;
        int          wr_seen;
        int          acks_seen;
        bit          fe;
        bit          de;
        logic [1:0]  sz;
        reset   = 1'b1;
        fill    = 1'b1;
        pre_we  = 1'b0;
        pre_idx = '0;
        pre_word = 32'h0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 2'b00;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) init_img[i] = 8'($urandom);
        ref_mem = init_img;
        model_last_data = 1'b1;
        @(posedge clock);
        #1;
        fill = 1'b0;
        @(negedge clock);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_if_err", 32'(if_err), 32'd0);
        check("rst_d_err", 32'(d_err), 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_rw", 32'(mem_read_write), 32'd0);
        check("rst_mem_address", mem_address, BASE);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_state_idle", 32'(dbg_state), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // First tie after reset goes to fetch, then sides alternate.
        run_pair(1'b1, BASE + 32'h10, 1'b1, 1'b0, 2'b10, BASE + 32'h14, 32'h0);
        run_pair(1'b1, BASE + 32'h18, 1'b1, 1'b0, 2'b10, BASE + 32'h1c, 32'h0);
        run_pair(1'b1, BASE + 32'h20, 1'b1, 1'b1, 2'b10, BASE + 32'h24, 32'hCAFE_F00D);

        preload(0, 32'hDEAD_BEEF);
        run_pair(1'b1, BASE, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

        preload(4, 32'h4433_2211);
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, BASE + 32'h5, 32'h0000_00AA);
        check("byte_store_image", phys_word(4), 32'h4433_AA11);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, BASE + 32'h4, 32'h0);
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, BASE + 32'h8, 32'h0000_BEEF);

        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h00FF_FFFC, 32'h0);
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, BASE + 32'(DEPTH) - 32'd3, 32'h1111_1111);
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 2'b11, BASE + 32'h8, 32'h2222_2222);
        run_pair(1'b1, BASE + 32'h2, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, BASE + 32'(DEPTH) - 32'd4, 32'h1234_5678);
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, BASE + 32'(DEPTH) - 32'd4, 32'h0);
        check("top_word_image", phys_word(DEPTH - 4), 32'h1234_5678);

        // Reset lands in the MERGE cycle of a byte store: nothing must be written or acked.
        preload(32'h30, 32'h8899_AABB);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_size  = 2'b00;
        d_addr  = BASE + 32'h30;
        d_wdata = 32'h0000_0055;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("merge_mem_address", mem_address, BASE + 32'h30);
        check("merge_no_write", 32'(mem_read_write), 32'd0);
        reset = 1'b1;
        d_req = 1'b0;
        wr_seen   = 0;
        acks_seen = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (mem_read_write) wr_seen++;
            if (if_ack || d_ack) acks_seen++;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_last_data = 1'b1;
        check("rst_cut_writes", 32'(wr_seen), 32'd0);
        check("rst_cut_acks", 32'(acks_seen), 32'd0);
        check("rst_cut_state_idle", 32'(dbg_state), 32'd0);
        check("rst_cut_word", phys_word(32'h30), 32'h8899_AABB);
        run_pair(1'b1, BASE + 32'h30, 1'b1, 1'b0, 2'b10, BASE + 32'h30, 32'h0);

        for (int n = 0; n < 150; n++) begin
            fe = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            if (!fe && !de) fe = 1'b1;
            sz = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            run_pair(fe, rand_addr(1'b0), de, 1'($urandom_range(0, 1)), sz,
                     rand_addr(1'b1), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_b[i] !== ref_mem[i]) mism++;
        check("mem_image_diff_bytes", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
